// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and types for the RV32 MEM-stage load/store unit
//
// Purpose : funct3 size/sign codes, IDLE/ACCESS state encoding, timeout counter
//           width, the latched memory-op record and small decode helpers.
// Ports   : none (package).
package mem_stage_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Everything about an accepted memory op that must stay stable while the
    // request is outstanding.
    typedef struct packed {
        logic [1:0]  control_wb;
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  write_reg;
    } mem_op_t;

    // Reserved encodings fall through to word size.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - combinational byte-lane steering and load extension
//
// Purpose : derives store byte enables and lane-replicated store data, selects
//           and sign/zero-extends the load lane, and flags misaligned accesses.
//           The misalign flag is only live when MISALIGN_TRAP_EN is defined;
//           otherwise it is tied to 0 and offending low address bits are
//           ignored (halfwords use a[1], words use the whole word).
// Ports   : funct3_i      size/sign code
//           addr_lo_i     effective address bits [1:0]
//           store_data_i  store data (rs2)
//           rdata_i       word returned by data memory
//           wstrb_o       byte enables for a store
//           wdata_o       lane-replicated store data
//           load_data_o   extended load data
//           misalign_o    access violates its natural alignment
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    size_e       size;
    logic        is_unsigned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        size        = f3_size(funct3_i);
        is_unsigned = f3_unsigned(funct3_i);
        wstrb_o     = 4'hF;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        case (size)
            SZ_B: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = is_unsigned ? {24'h0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                wstrb_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = is_unsigned ? {16'h0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                wstrb_o     = 4'hF;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (f3_size(funct3_i))
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = addr_lo_i[0];
            default: misalign_o = (addr_lo_i != 2'b00);
        endcase
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 MEM-stage load/store unit with req/ack data-memory port
//
// Purpose : accepts an instruction from EX/MEM; ALU ops pass through with one
//           cycle of latency, loads/stores run a req/ack transaction to data
//           memory while stalling upstream, with a TIMEOUT_CYCLES abort that
//           reports bus_err_out. Results feed mem_wb2.
//           Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses are
//           not issued and report misalign_out instead.
// Ports   : clock, reset (async, active low)
//           EX/MEM in : valid_in, control_wb_in, memread_in, memwrite_in,
//                       funct3_in, alu_result_in, write_data_in, write_reg_in
//           upstream  : stall_out
//           dmem      : dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
//                       dmem_ack, dmem_rdata
//           mem_wb2   : valid_out, control_wb_out, read_data_out,
//                       alu_result_out, write_reg_out, bus_err_out, misalign_out
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [1:0]  control_wb_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic [1:0]  control_wb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  write_reg_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_op_t          op_q, op_d;
    logic             valid_q, valid_d;
    logic [1:0]       cwb_q, cwb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      alu_q, alu_d;
    logic [4:0]       wreg_q, wreg_d;
    logic             berr_q, berr_d;
    logic             mis_q, mis_d;

    logic             in_access;
    logic [2:0]       lsa_funct3;
    logic [1:0]       lsa_addr_lo;
    logic [31:0]      lsa_store_data;
    logic [3:0]       lsa_wstrb;
    logic [31:0]      lsa_wdata;
    logic [31:0]      lsa_load_data;
    logic             lsa_misalign;

    assign in_access = (state_q == ST_ACCESS);

    // In IDLE the aligner looks at the incoming op so the misalign decision is
    // made at acceptance; in ACCESS it looks at the latched op so the bus
    // fields stay stable and the load lane matches the issued address.
    assign lsa_funct3     = in_access ? op_q.funct3     : funct3_in;
    assign lsa_addr_lo    = in_access ? op_q.addr[1:0]  : alu_result_in[1:0];
    assign lsa_store_data = in_access ? op_q.wdata      : write_data_in;

    load_store_align u_align (
        .funct3_i     (lsa_funct3),
        .addr_lo_i    (lsa_addr_lo),
        .store_data_i (lsa_store_data),
        .rdata_i      (dmem_rdata),
        .wstrb_o      (lsa_wstrb),
        .wdata_o      (lsa_wdata),
        .load_data_o  (lsa_load_data),
        .misalign_o   (lsa_misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        valid_d = 1'b0;
        cwb_d   = 2'b00;
        rdata_d = 32'h0;
        alu_d   = 32'h0;
        wreg_d  = 5'd0;
        berr_d  = 1'b0;
        mis_d   = 1'b0;

        if (in_access) begin
            // valid_in is ignored here, including on the edge that returns to
            // IDLE: upstream is still stalled and holds the next instruction.
            cnt_d = cnt_q + 1'b1;
            if (dmem_ack) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                valid_d = 1'b1;
                cwb_d   = op_q.control_wb;
                rdata_d = op_q.we ? 32'h0 : lsa_load_data;
                alu_d   = op_q.addr;
                wreg_d  = op_q.write_reg;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                valid_d = 1'b1;
                cwb_d   = {1'b0, op_q.control_wb[0]};
                alu_d   = op_q.addr;
                wreg_d  = op_q.write_reg;
                berr_d  = 1'b1;
            end
        end else if (valid_in) begin
            if ((memread_in || memwrite_in) && !lsa_misalign) begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
                op_d    = '{control_wb: control_wb_in,
                            we:         memwrite_in,
                            funct3:     funct3_in,
                            addr:       alu_result_in,
                            wdata:      write_data_in,
                            write_reg:  write_reg_in};
            end else begin
                valid_d = 1'b1;
                cwb_d   = control_wb_in;
                alu_d   = alu_result_in;
                wreg_d  = write_reg_in;
                // Only a trapped memory op reaches here with memread/memwrite set.
                if (memread_in || memwrite_in) begin
                    cwb_d[1] = 1'b0;
                    mis_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            cwb_q   <= 2'b00;
            rdata_q <= 32'h0;
            alu_q   <= 32'h0;
            wreg_q  <= 5'd0;
            berr_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            cwb_q   <= cwb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            wreg_q  <= wreg_d;
            berr_q  <= berr_d;
            mis_q   <= mis_d;
        end
    end

    // Bus fields are gated by the registered state so they are all zero in
    // IDLE and during reset; loads drive zero strobes and data.
    assign stall_out  = in_access;
    assign dmem_req   = in_access;
    assign dmem_we    = in_access & op_q.we;
    assign dmem_addr  = in_access ? {op_q.addr[31:2], 2'b00} : 32'h0;
    assign dmem_wstrb = (in_access && op_q.we) ? lsa_wstrb : 4'h0;
    assign dmem_wdata = (in_access && op_q.we) ? lsa_wdata : 32'h0;

    assign valid_out      = valid_q;
    assign control_wb_out = cwb_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign write_reg_out  = wreg_q;
    assign bus_err_out    = berr_q;
    assign misalign_out   = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in, memread_in, memwrite_in, dmem_ack;
    logic [1:0]  control_wb_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, write_data_in, dmem_rdata;
    logic [4:0]  write_reg_in;
    logic        stall_out, dmem_req, dmem_we, valid_out, bus_err_out, misalign_out;
    logic [31:0] dmem_addr, dmem_wdata, read_data_out, alu_result_out;
    logic [3:0]  dmem_wstrb;
    logic [1:0]  control_wb_out;
    logic [4:0]  write_reg_out;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .control_wb_in(control_wb_in), .memread_in(memread_in),
        .memwrite_in(memwrite_in), .funct3_in(funct3_in),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .write_reg_in(write_reg_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_out(valid_out), .control_wb_out(control_wb_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .write_reg_out(write_reg_out), .bus_err_out(bus_err_out),
        .misalign_out(misalign_out)
    );

    typedef struct {
        logic [1:0]  cwb;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        int          delay;     // ack seen in stall cycle delay+1; >= TO means never
        int          e_stall;
        logic [1:0]  e_cwb;
        logic [31:0] e_rdo;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_addr;
        logic        e_berr;
        logic        e_mis;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur = "";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur, nm, act, exp);
        end
    endtask

    // Reference model: derives the expected outcome from the architectural rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        logic [31:0] idx = v.addr % 4;
        logic [31:0] val;
        bit          mem = v.rd || v.wr;
        bit          is_b = (v.f3 == 3'd0) || (v.f3 == 3'd4);
        bit          is_h = (v.f3 == 3'd1) || (v.f3 == 3'd5);
        bit          uns = (v.f3 == 3'd4) || (v.f3 == 3'd5);
        bit          mis = 1'b0;
        bit          tout;
`ifdef MISALIGN_TRAP_EN
        if (mem) mis = is_h ? (idx % 2 != 0) : (!is_b && idx != 0);
`endif
        tout      = mem && !mis && (v.delay >= TO);
        r.e_stall = (!mem || mis) ? 0 : (tout ? TO : v.delay + 1);
        r.e_addr  = v.addr - idx;
        r.e_strb  = 4'h0;
        r.e_wdata = 32'h0;
        if (v.wr) begin
            if (is_b) begin
                r.e_strb  = 4'(1 << idx);
                r.e_wdata = (v.wd & 32'hFF) * 32'h01010101;
            end else if (is_h) begin
                r.e_strb  = 4'(3 << (2 * (idx / 2)));
                r.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
            end else begin
                r.e_strb  = 4'hF;
                r.e_wdata = v.wd;
            end
        end
        if (is_b) begin
            val = (v.rdata >> (8 * idx)) & 32'hFF;
            if (!uns && val >= 128) val = val - 256;
        end else if (is_h) begin
            val = (v.rdata >> (16 * (idx / 2))) & 32'hFFFF;
            if (!uns && val >= 32768) val = val - 65536;
        end else begin
            val = v.rdata;
        end
        r.e_rdo  = (v.rd && !v.wr && !mis && !tout) ? val : 32'h0;
        r.e_cwb  = (mis || tout) ? {1'b0, v.cwb[0]} : v.cwb;
        r.e_berr = tout;
        r.e_mis  = mis;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int ns;
        bit seen;
        bit bus_bad;
        cur = tag;
        @(negedge clock);
        valid_in = 1'b1; control_wb_in = v.cwb; memread_in = v.rd; memwrite_in = v.wr;
        funct3_in = v.f3; alu_result_in = v.addr; write_data_in = v.wd;
        write_reg_in = v.wreg; dmem_rdata = v.rdata; dmem_ack = 1'b0;
        @(posedge clock); #1;
        valid_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
        ns = 0; seen = 1'b0; bus_bad = 1'b0;
        for (int c = 0; c < TO + 4 && !seen; c++) begin
            if (stall_out) begin
                ns++;
                if ({dmem_req, dmem_we, dmem_wstrb} !== {1'b1, v.wr, v.e_strb} ||
                    dmem_addr !== v.e_addr || dmem_wdata !== v.e_wdata) bus_bad = 1'b1;
                if (ns == 1) begin
                    chk("dmem_req", dmem_req, 1);
                    chk("dmem_we", dmem_we, v.wr);
                    chk("dmem_addr", dmem_addr, v.e_addr);
                    chk("dmem_wstrb", dmem_wstrb, v.e_strb);
                    chk("dmem_wdata", dmem_wdata, v.e_wdata);
                end
                dmem_ack = (ns == v.delay + 1);
            end else if (valid_out) begin
                seen = 1'b1;
                chk("stall_cycles", ns, v.e_stall);
                chk("req_low_at_valid", dmem_req, 0);
                chk("control_wb_out", control_wb_out, v.e_cwb);
                chk("read_data_out", read_data_out, v.e_rdo);
                chk("alu_result_out", alu_result_out, v.addr);
                chk("write_reg_out", write_reg_out, v.wreg);
                chk("bus_err_out", bus_err_out, v.e_berr);
                chk("misalign_out", misalign_out, v.e_mis);
            end
            @(posedge clock); #1;
            dmem_ack = 1'b0;
        end
        chk("valid_seen", seen, 1);
        if (v.e_stall > 0) chk("bus_stable", bus_bad, 0);
        chk("pulse_one_cycle", {valid_out, bus_err_out, misalign_out}, 0);
    endtask

    vec_t tbl[12];
    vec_t v;
    int   ns;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            cwb   rd wr f3      addr      wd            rdata         wreg  dly   stall e_cwb e_rdo         strb     wdata         addr      berr mis
        tbl[0]  = '{2'b10, 0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        5'd3,  2,    3,    2'b10, 32'h0,        4'hF,    32'hDEADBEEF, 32'h104, 0, 0};
        tbl[1]  = '{2'b11, 1, 0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 5'd5,  0,    1,    2'b11, 32'hFFFFFF80, 4'h0,    32'h0,        32'h200, 0, 0};
        tbl[2]  = '{2'b11, 1, 0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 5'd6,  0,    1,    2'b11, 32'h00000080, 4'h0,    32'h0,        32'h200, 0, 0};
        tbl[3]  = '{2'b00, 0, 1, 3'b001, 32'h002, 32'h0000ABCD, 32'h0,        5'd0,  1,    2,    2'b00, 32'h0,        4'b1100, 32'hABCDABCD, 32'h000, 0, 0};
        tbl[4]  = '{2'b11, 1, 0, 3'b001, 32'h002, 32'h0,        32'h7FFF0000, 5'd9,  4,    5,    2'b11, 32'h00007FFF, 4'h0,    32'h0,        32'h000, 0, 0};
        tbl[5]  = '{2'b11, 1, 0, 3'b010, 32'h300, 32'h0,        32'h11111111, 5'd10, TO,   TO,   2'b01, 32'h0,        4'h0,    32'h0,        32'h300, 1, 0};
        tbl[6]  = '{2'b11, 1, 0, 3'b010, 32'h304, 32'h0,        32'h12345678, 5'd11, TO-1, TO,   2'b11, 32'h12345678, 4'h0,    32'h0,        32'h304, 0, 0};
`ifdef MISALIGN_TRAP_EN
        tbl[7]  = '{2'b11, 1, 0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 5'd12, 0,    0,    2'b01, 32'h0,        4'h0,    32'h0,        32'h100, 0, 1};
`else
        tbl[7]  = '{2'b11, 1, 0, 3'b010, 32'h101, 32'h0,        32'hCAFEF00D, 5'd12, 0,    1,    2'b11, 32'hCAFEF00D, 4'h0,    32'h0,        32'h100, 0, 0};
`endif
        tbl[8]  = '{2'b10, 0, 0, 3'b000, 32'h055, 32'h0,        32'h0,        5'd13, 0,    0,    2'b10, 32'h0,        4'h0,    32'h0,        32'h0,   0, 0};
        tbl[9]  = '{2'b00, 0, 1, 3'b000, 32'h001, 32'h123456A5, 32'h0,        5'd0,  0,    1,    2'b00, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h000, 0, 0};
        tbl[10] = '{2'b11, 1, 0, 3'b001, 32'h000, 32'h0,        32'h00008001, 5'd14, 0,    1,    2'b11, 32'hFFFF8001, 4'h0,    32'h0,        32'h000, 0, 0};
        tbl[11] = '{2'b11, 1, 0, 3'b011, 32'h008, 32'h0,        32'hF00DFACE, 5'd15, 1,    2,    2'b11, 32'hF00DFACE, 4'h0,    32'h0,        32'h008, 0, 0};

        reset = 1'b0; valid_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
        dmem_ack = 1'b0; control_wb_in = 2'b00; funct3_in = 3'b000;
        alu_result_in = 32'h0; write_data_in = 32'h0; dmem_rdata = 32'h0; write_reg_in = 5'd0;

        cur = "reset";
        #1;
        chk("ctrl_outs", {stall_out, dmem_req, dmem_we, dmem_wstrb, valid_out, control_wb_out,
                          write_reg_out, bus_err_out, misalign_out}, 0);
        chk("dmem_addr", dmem_addr, 0);
        chk("dmem_wdata", dmem_wdata, 0);
        chk("read_data_out", read_data_out, 0);
        chk("alu_result_out", alu_result_out, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        // Next instruction held by the stalled upstream must wait for IDLE.
        cur = "b2b";
        @(negedge clock);
        valid_in = 1'b1; memwrite_in = 1'b1; funct3_in = 3'b010; control_wb_in = 2'b00;
        alu_result_in = 32'h104; write_data_in = 32'h01020304; write_reg_in = 5'd1;
        @(posedge clock); #1;
        memwrite_in = 1'b0; alu_result_in = 32'h55; control_wb_in = 2'b10; write_reg_in = 5'd7;
        ns = 0;
        for (int c = 0; c < 10 && stall_out; c++) begin
            ns++;
            dmem_ack = (ns == 3);
            @(posedge clock); #1;
            dmem_ack = 1'b0;
        end
        chk("stall_cycles", ns, 3);
        chk("sw_valid", valid_out, 1);
        chk("sw_alu_result", alu_result_out, 32'h104);
        chk("sw_cwb", control_wb_out, 2'b00);
        @(posedge clock); #1;
        valid_in = 1'b0;
        chk("alu_valid", valid_out, 1);
        chk("alu_result", alu_result_out, 32'h55);
        chk("alu_wreg", write_reg_out, 7);
        chk("alu_no_stall", stall_out, 0);
        @(posedge clock); #1;
        chk("idle_after", valid_out, 0);

        // Asynchronous reset in the middle of an access.
        cur = "t6";
        @(negedge clock);
        valid_in = 1'b1; memread_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h400;
        @(posedge clock); #1;
        valid_in = 1'b0; memread_in = 1'b0;
        chk("req_before_reset", dmem_req, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        chk("req_in_reset", dmem_req, 0);
        chk("stall_in_reset", stall_out, 0);
        chk("valid_in_reset", valid_out, 0);
        @(negedge clock);
        reset = 1'b1;
        v = '{2'b10, 0, 0, 3'b000, 32'h55, 32'h0, 32'h0, 5'd2, 0, 0, 2'b10, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0};
        run_op(v, "t6_alu");

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v.cwb   = 2'($urandom_range(0, 3));
            v.rd    = (kind == 1);
            v.wr    = (kind == 2);
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.wd    = $urandom;
            v.rdata = $urandom;
            v.wreg  = 5'($urandom_range(0, 31));
            v.delay = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 6);
            run_op(model(v), $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
                chk("bubble_no_valid", valid_out, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
